// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants for the data-memory access arbiter.
//   - FSM state encodings (IDLE, ACCESS, RESP)
//   - requester port ids (CPU = port 0, DMA = port 1)
//   - default parking address driven to the memory between accesses
//   - addr_in_range(): full-width range check against the memory depth
package dmem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [31:0] DEFAULT_PARK_ADDR = 32'hFFFF_FFFF;

    // Compare the whole 32-bit address; upper bits must never alias into the array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return ({1'b0, addr} < 33'(depth));
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection between the two requesters.
//
// Build option: define DMEM_RR_EN for round-robin on ties (the port that was not
// granted last wins). Without it, port 0 has fixed priority and port 1 may starve.
//
// Ports:
//   req     in   2  request lines, bit 0 = CPU port, bit 1 = DMA port
//   last    in   1  id of the port granted most recently
//   winner  out  1  id of the selected port (meaningful when valid)
//   valid   out  1  at least one request is pending
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

`ifdef DMEM_RR_EN
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = PORT_DMA;
        end
    end
`else
    // The last-grant pointer only matters for round-robin.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (!req[0] && req[1]) begin
            winner = PORT_DMA;
        end
    end
`endif

endmodule

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: shares one 256 x 32 data memory between the CPU load/store
// stage (port 0) and the DMA/loader/debug port (port 1). Each access holds the
// address, data and strobe for MEM_LATENCY cycles, then returns a one-cycle done
// (with read data on reads). Out-of-range addresses never touch the memory and
// complete with err. All outputs are registered.
//
// Build option: DMEM_RR_EN selects round-robin tie-breaking (see dmem_arb_pick).
//
// Parameters:
//   MEM_LATENCY  cycles the strobes are held per access (1..15)
//   DEPTH        number of memory words; addresses >= DEPTH are out of range
//   PARK_ADDR    address driven while idle so every access is an address change
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   rN_req/we/addr/wdata       requester N command, held from req until done
//   rN_gnt                     one-cycle pulse, request accepted
//   rN_done/err                one-cycle pulse, access complete / address out of range
//   rN_rdata                   read data, valid with rN_done on reads
//   mem_address/write_data     to the data memory
//   mem_read/mem_write         memory strobes
//   mem_read_data              from the data memory
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] PARK_ADDR   = DEFAULT_PARK_ADDR
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              err_pend_q, err_pend_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic              pick_win;
    logic              pick_valid;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    dmem_arb_pick u_pick (
        .req    ({r1_req, r0_req}),
        .last   (last_q),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    assign sel_we    = pick_win ? r1_we    : r0_we;
    assign sel_addr  = pick_win ? r1_addr  : r0_addr;
    assign sel_wdata = pick_win ? r1_wdata : r0_wdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        win_d       = win_q;
        we_d        = we_q;
        err_pend_d  = err_pend_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        err_d       = 2'b00;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d           = pick_win;
                    last_d          = pick_win;
                    we_d            = sel_we;
                    gnt_d[pick_win] = 1'b1;
                    cnt_d           = CNT_INIT;
                    if (addr_in_range(sel_addr, DEPTH)) begin
                        mem_addr_d = sel_addr;
                        if (sel_we) begin
                            mem_wdata_d = sel_wdata;
                        end
                        mem_rd_d = ~sel_we;
                        mem_wr_d = sel_we;
                        state_d  = ST_ACCESS;
                    end else begin
                        // Memory is never touched; error is reported from RESP.
                        err_pend_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d[win_q] = mem_read_data;
                    end
                    mem_rd_d      = 1'b0;
                    mem_wr_d      = 1'b0;
                    mem_addr_d    = PARK_ADDR;
                    done_d[win_q] = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                // An out-of-range access spends one extra RESP cycle so its done
                // lands one cycle after its grant rather than on top of it.
                if (err_pend_q) begin
                    err_pend_d    = 1'b0;
                    done_d[win_q] = 1'b1;
                    err_d[win_q]  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= PORT_DMA;
            win_q       <= PORT_CPU;
            we_q        <= 1'b0;
            err_pend_q  <= 1'b0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata_q     <= '0;
            mem_addr_q  <= PARK_ADDR;
            mem_wdata_q <= 32'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            win_q       <= win_d;
            we_q        <= we_d;
            err_pend_q  <= err_pend_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign r0_gnt         = gnt_q[0];
    assign r0_done        = done_q[0];
    assign r0_err         = err_q[0];
    assign r0_rdata       = rdata_q[0];
    assign r1_gnt         = gnt_q[1];
    assign r1_done        = done_q[1];
    assign r1_err         = err_q[1];
    assign r1_rdata       = rdata_q[1];
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_read       = mem_rd_q;
    assign mem_write      = mem_wr_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter (default MEM_LATENCY = 2, DEPTH = 256).
// Expected gnt/done events (port, cycle, err, rdata) are queued by the stimulus;
// a negedge monitor pops and compares every gnt/done pulse the DUT produces.
module tb_dmem_access_arbiter;

    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    bit   [31:0] mem [0:255];
    logic        preload;

    typedef struct {
        bit          kind;   // 0 = gnt, 1 = done
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc;
    int          tests;
    int          fails;
    logic [31:0] exp_rd0, exp_rd1;

    dmem_access_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .r0_req         (r0_req),
        .r0_we          (r0_we),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_gnt         (r0_gnt),
        .r0_done        (r0_done),
        .r0_err         (r0_err),
        .r0_rdata       (r0_rdata),
        .r1_req         (r1_req),
        .r1_we          (r1_we),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_gnt         (r1_gnt),
        .r1_done        (r1_done),
        .r1_err         (r1_err),
        .r1_rdata       (r1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: combinational read, write on the clock while strobed.
    always @(posedge clk) begin
        if (preload) begin
            mem[5]   <= 32'hDEAD_BEEF;
            mem[255] <= 32'hA5A5_0FF0;
        end else if (mem_write && mem_address < 32'd256) begin
            mem[mem_address[7:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0BAD_0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit kind, input bit port, input bit err, input logic [31:0] rd,
                        input int c);
        ev_t e;
        e.kind  = kind;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input bit kind, input bit port, input bit err, input logic [31:0] rd);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d port=%0d cycle=%0d, expected none",
                     kind, port, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.port != port || e.cyc != cyc ||
                (kind && (e.err != err || e.rdata !== rd))) begin
                fails++;
                $display("FAIL event: got kind=%0d port=%0d cyc=%0d err=%0d rdata=%h, expected kind=%0d port=%0d cyc=%0d err=%0d rdata=%h",
                         kind, port, cyc, err, rd, e.kind, e.port, e.cyc, e.err, e.rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        if (r0_gnt)  mon_ev(1'b0, 1'b0, 1'b0, 32'd0);
        if (r1_gnt)  mon_ev(1'b0, 1'b1, 1'b0, 32'd0);
        if (r0_done) mon_ev(1'b1, 1'b0, r0_err, r0_rdata);
        if (r1_done) mon_ev(1'b1, 1'b1, r1_err, r1_rdata);
    end

    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port) begin
            r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
        end else begin
            r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
        end
    endtask

    // Waits for the port's done (bounded), drops req in that cycle, then steps one more cycle.
    task automatic wait_done(input bit port, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (port ? r1_done : r0_done) seen = 1'b1;
        end
        if (port) r1_req = 1'b0;
        else      r0_req = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: port %0d got no done, required done within %0d cycles",
                     port, bound);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        tests = 0; fails = 0;
        exp_rd0 = 32'd0; exp_rd1 = 32'd0;
        reset = 1'b1; preload = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
        chk("rst_r0_done", {31'd0, r0_done}, 32'd0);
        chk("rst_r0_err", {31'd0, r0_err}, 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'd0);
        chk("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
        chk("rst_r1_done", {31'd0, r1_done}, 32'd0);
        chk("rst_r1_rdata", r1_rdata, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, PARK);
        chk("rst_mem_wdata", mem_write_data, 32'd0);

        // Single read on port 0
        c = cyc;
        issue(0, 0, 32'd5, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 3);
        exp_rd0 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_strobe_c1", {31'd0, mem_read}, 32'd1);
        chk("rd_addr_c1", mem_address, 32'd5);
        chk("rd_no_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        chk("rd_strobe_c2", {31'd0, mem_read}, 32'd1);
        wait_done(0, 20);
        chk("rd_strobe_off", {31'd0, mem_read}, 32'd0);
        chk("rd_parked", mem_address, PARK);
        chk("rd_rdata_held", r0_rdata, 32'hDEAD_BEEF);

        // Port 1 write then read of the same address
        c = cyc;
        issue(1, 1, 32'd10, 32'h1234_5678);
        push(0, 1, 0, 32'd0, c + 1);
        push(1, 1, 0, exp_rd1, c + 3);
        @(negedge clk);
        chk("wr_strobe", {31'd0, mem_write}, 32'd1);
        chk("wr_no_read", {31'd0, mem_read}, 32'd0);
        chk("wr_addr", mem_address, 32'd10);
        chk("wr_data", mem_write_data, 32'h1234_5678);
        wait_done(1, 20);
        chk("wr_parked_between", mem_address, PARK);
        c = cyc;
        issue(1, 0, 32'd10, 32'd0);
        push(0, 1, 0, 32'd0, c + 1);
        push(1, 1, 0, 32'h1234_5678, c + 3);
        exp_rd1 = 32'h1234_5678;
        @(negedge clk);
        chk("rb_addr", mem_address, 32'd10);
        chk("rb_strobe", {31'd0, mem_read}, 32'd1);
        wait_done(1, 20);

        // First tie: port 0 wins in both builds
        c = cyc;
        issue(0, 0, 32'd5, 32'd0);
        issue(1, 0, 32'd10, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 3);
        push(0, 1, 0, 32'd0, c + 5);
        push(1, 1, 0, 32'h1234_5678, c + 7);
        fork
            wait_done(0, 20);
            wait_done(1, 30);
        join

        // Out-of-range read on port 0
        c = cyc;
        issue(0, 0, 32'd300, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 1, exp_rd0, c + 2);
        @(negedge clk);
        chk("oor_no_read", {31'd0, mem_read}, 32'd0);
        chk("oor_no_write", {31'd0, mem_write}, 32'd0);
        chk("oor_parked", mem_address, PARK);
        wait_done(0, 20);

        // Second tie, port 0 granted last
        c = cyc;
        issue(0, 0, 32'd5, 32'd0);
        issue(1, 0, 32'd255, 32'd0);
`ifdef DMEM_RR_EN
        push(0, 1, 0, 32'd0, c + 1);
        push(1, 1, 0, 32'hA5A5_0FF0, c + 3);
        push(0, 0, 0, 32'd0, c + 5);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 7);
`else
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 3);
        push(0, 1, 0, 32'd0, c + 5);
        push(1, 1, 0, 32'hA5A5_0FF0, c + 7);
`endif
        fork
            wait_done(0, 30);
            wait_done(1, 30);
        join

        // Reset in the middle of a write: no done, outputs back to reset values at once
        c = cyc;
        issue(0, 1, 32'd20, 32'hCAFE_0020);
        push(0, 0, 0, 32'd0, c + 1);
        @(negedge clk);
        chk("mid_write_strobe", {31'd0, mem_write}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_write", {31'd0, mem_write}, 32'd0);
        chk("mid_rst_read", {31'd0, mem_read}, 32'd0);
        chk("mid_rst_addr", mem_address, PARK);
        chk("mid_rst_rdata", r0_rdata, 32'd0);
        r0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        @(negedge clk);
        c = cyc;
        issue(0, 1, 32'd20, 32'hBEEF_0020);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'd0, c + 3);
        wait_done(0, 20);
        c = cyc;
        issue(0, 0, 32'd20, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hBEEF_0020, c + 3);
        exp_rd0 = 32'hBEEF_0020;
        wait_done(0, 20);

        // Boundaries: no truncation of high bits, DEPTH itself is out, DEPTH-1 is in
        c = cyc;
        issue(0, 0, 32'h8000_0005, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 1, exp_rd0, c + 2);
        wait_done(0, 20);
        c = cyc;
        issue(0, 0, 32'd256, 32'd0);
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 1, exp_rd0, c + 2);
        wait_done(0, 20);
        c = cyc;
        issue(1, 0, 32'd255, 32'd0);
        push(0, 1, 0, 32'd0, c + 1);
        push(1, 1, 0, 32'hA5A5_0FF0, c + 3);
        exp_rd1 = 32'hA5A5_0FF0;
        wait_done(1, 20);

        // Port 0 re-requests back to back while port 1 waits
        c = cyc;
        issue(0, 0, 32'd5, 32'd0);
        issue(1, 0, 32'd10, 32'd0);
`ifdef DMEM_RR_EN
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 3);
        push(0, 1, 0, 32'd0, c + 5);
        push(1, 1, 0, 32'h1234_5678, c + 7);
        push(0, 0, 0, 32'd0, c + 9);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 11);
        push(0, 0, 0, 32'd0, c + 13);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 15);
`else
        push(0, 0, 0, 32'd0, c + 1);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 3);
        push(0, 0, 0, 32'd0, c + 5);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 7);
        push(0, 0, 0, 32'd0, c + 9);
        push(1, 0, 0, 32'hDEAD_BEEF, c + 11);
        push(0, 1, 0, 32'd0, c + 13);
        push(1, 1, 0, 32'h1234_5678, c + 15);
`endif
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) issue(0, 0, 32'd5, 32'd0);
                    wait_done(0, 40);
                end
            end
            wait_done(1, 40);
        join

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
Shares the single data memory (256 x 32, word-addressed, combinational-style read/write strobes, address-change sensitive) between two requesters. Port 0 is the CPU load/store stage; port 1 is the DMA/loader/debug port.
Each port uses a req/gnt/done handshake. The block sequences the memory strobes for a fixed number of cycles, captures read data, and returns it with a one-cycle done pulse.
Sits between the MEM-stage/DMA logic and Data_Mem; it is the only driver of Data_Mem's inputs.

Parameters:
- MEM_LATENCY, 2: cycles strobes/address are held per access; legal range 1-15.
- DEPTH, 256: memory words; an address >= DEPTH is out of range.
- PARK_ADDR, 32'hFFFF_FFFF: address driven to memory while no access is active.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request; held until r0_done
- r0_we  in  1  port 0: 1 = write, 0 = read
- r0_addr  in  32  port 0 word address
- r0_wdata  in  32  port 0 write data
- r0_gnt  out  1  one-cycle pulse; port 0 request accepted
- r0_done  out  1  one-cycle pulse; port 0 access complete
- r0_err  out  1  valid with r0_done; address out of range
- r0_rdata  out  32  read data, valid with r0_done on reads
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata: same widths and meanings for port 1
- mem_address  out  32  to Data_Mem address
- mem_write_data  out  32  to Data_Mem write_data
- mem_read  out  1  to Data_Mem signal_mem_read
- mem_write  out  1  to Data_Mem signal_mem_write
- mem_read_data  in  32  from Data_Mem read_data

Behaviour:
- All outputs are registered.
- Reset values: gnt/done/err = 0, rdata = 0, mem_read = mem_write = 0, mem_address = PARK_ADDR, mem_write_data = 0, state = IDLE, latency counter = 0, RR pointer = port 1.
- Reset asserted mid-access: block returns to the reset values immediately (asynchronous). No done is issued; the requester must re-request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, at edge k with any req high:
  - pick the winner;
  - latch its we/addr/wdata;
  - pulse its gnt;
  - counter = MEM_LATENCY - 1.
  - Address in range: drive mem_address = addr, mem_write_data = wdata (writes), and mem_read = !we or mem_write = we; go to ACCESS.
  - Address out of range: strobes stay low, address stays parked; go directly to RESP with err = 1.
- ACCESS: hold address, data and strobe; decrement the counter each edge. At the edge where counter == 0:
  - capture mem_read_data into the winner's rdata (reads only; rdata is unchanged on writes);
  - deassert strobes; set mem_address = PARK_ADDR;
  - pulse the winner's done; go to RESP.
- RESP: done/err high for this cycle only; next edge returns to IDLE and clears done/err.
- Timing: req sampled at edge k -> gnt visible after edge k; done visible after edge k+MEM_LATENCY. The next grant is no earlier than edge k+MEM_LATENCY+2.
- Parking the address between accesses guarantees every access presents an address change to the memory, including back-to-back accesses to the same address.
- Requester rules:
  - hold req and operands stable from req until done;
  - drop req in the cycle done is seen;
  - changing operands after gnt has no effect (values are latched).
- Simultaneous requests: the loser keeps req high and gets no gnt. It is served in a later IDLE cycle.
- Address width rule: compare the full 32-bit address against DEPTH; no truncation or wrap-around.
- err is never asserted on in-range accesses.

Optional Feature:
- DMEM_RR_EN defined: round-robin arbitration. On a tie the port not granted last wins; the pointer updates on every grant, and its reset value (port 1 last) means port 0 wins the first tie.
- DMEM_RR_EN undefined: fixed priority, port 0 always wins ties. Port 1 may starve; this is accepted.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - port-id constants PORT_CPU = 0, PORT_DMA = 1;
  - default PARK_ADDR constant.
- One combinational sub-module is natural: dmem_arb_pick (inputs: req[1:0], last winner; output: winner id and valid), containing the DMEM_RR_EN logic.
- FSM, counter and datapath latches stay in the top module.

Test Plan:
- Single read: r0 read addr 5 (mem[5] = 32'hDEAD_BEEF), MEM_LATENCY = 2 -> r0_gnt after edge k, mem_read high 2 cycles, r0_done and r0_rdata = 32'hDEAD_BEEF after edge k+2, r0_err = 0.
- Write then read of the same address: r1 writes 32'h1234_5678 to addr 10, then r1 reads addr 10 -> mem_address parks between the accesses; read returns 32'h1234_5678.
- Simultaneous requests: r0 and r1 both request at the same edge -> r0 served first. r1_gnt arrives exactly MEM_LATENCY+2 cycles after r0_gnt (both builds). With DMEM_RR_EN, a second simultaneous tie is granted to r1.
- Out of range: r0 read addr 300 -> no mem strobe, r0_done with r0_err = 1 one cycle after gnt, r0_rdata unchanged.
- Reset mid-access: assert reset during ACCESS -> strobes drop, mem_address = PARK_ADDR immediately, no done. After release, a re-request completes normally.
- Starvation check: without DMEM_RR_EN and r0 requesting continuously, r1 is never granted. With the macro, grants alternate r0, r1, r0, ...
